// File: rtl/io_intr_ctrl.sv
// Two-channel CPU interrupt controller: channel 1 is a reloadable periodic
// down-counter, channel 2 is a synchronized rising-edge detector on ext_ev.
module io_intr_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_out_cfg,
    input  logic [7:0] port_out_ctl,
    input  logic       ext_ev,
    output logic       intr1,
    output logic       intr2,
    output logic [7:0] port_in_status,
    output logic [7:0] port_in_count
);

    logic [7:0]             ctl_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   pend1_q, pend1_d, ovf1_q, ovf1_d;
    logic                   pend2_q, pend2_d, ovf2_q, ovf2_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [SYNC_STAGES:0]   fill_q;

    logic ack1, ack2, en1_rise, en1, en2;
    logic ev1, ev2;
    logic unused_ctl;

    assign unused_ctl = ^{port_out_ctl[7:6], port_out_ctl[3:2], ctl_q[7:6], ctl_q[3:2]};

    // Returns {pend, ovf}: a new event always sets pend and wins over ack;
    // ovf is only raised when the event lands on a still-pending, un-acked bit.
    function automatic logic [1:0] pend_next(input logic pend, input logic ovf,
                                             input logic ack, input logic ev);
        logic p, o;
        p = pend;
        o = ovf;
        if (ack) begin
            p = 1'b0;
            o = 1'b0;
        end
        if (ev) begin
            if (pend && !ack) o = 1'b1;
            p = 1'b1;
        end
        return {p, o};
    endfunction

    assign en1      = port_out_ctl[0];
    assign en2      = port_out_ctl[1];
    assign en1_rise = port_out_ctl[0] & ~ctl_q[0];
    assign ack1     = port_out_ctl[4] & ~ctl_q[4];
    assign ack2     = port_out_ctl[5] & ~ctl_q[5];

    // fill_q gates detection until edge_q holds a real post-reset sample, so a
    // line already high at reset release is not mistaken for an edge.
    assign ev2 = fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~edge_q & en2;

    always_comb begin
        cnt_d = cnt_q;
        ev1   = 1'b0;
        if (en1_rise) begin
            cnt_d = port_out_cfg;
        end else if (en1) begin
            if (cnt_q == 8'd0) begin
                if (port_out_cfg != 8'd0) begin
                    ev1   = 1'b1;
                    cnt_d = port_out_cfg;
                end
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        pend1_d = pend1_q;
        ovf1_d  = ovf1_q;
        pend2_d = pend2_q;
        ovf2_d  = ovf2_q;
        {pend1_d, ovf1_d} = pend_next(pend1_q, ovf1_q, ack1, ev1);
        {pend2_d, ovf2_d} = pend_next(pend2_q, ovf2_q, ack2, ev2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctl_q   <= 8'h00;
            cnt_q   <= 8'h00;
            pend1_q <= 1'b0;
            ovf1_q  <= 1'b0;
            pend2_q <= 1'b0;
            ovf2_q  <= 1'b0;
            sync_q  <= '0;
            edge_q  <= 1'b0;
            fill_q  <= '0;
        end else begin
            ctl_q   <= port_out_ctl;
            cnt_q   <= cnt_d;
            pend1_q <= pend1_d;
            ovf1_q  <= ovf1_d;
            pend2_q <= pend2_d;
            ovf2_q  <= ovf2_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_ev};
            edge_q  <= sync_q[SYNC_STAGES-1];
            fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign intr1          = pend1_q;
    assign intr2          = pend2_q;
    assign port_in_status = {2'b00, ctl_q[1], ctl_q[0], ovf2_q, ovf1_q, pend2_q, pend1_q};
    assign port_in_count  = cnt_q;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl: timer period/ack/overflow, external event
// latency, ack/event collision, en2 gating, mid-run reset.
module tb_io_intr_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] cfg;
    logic [7:0] ctl;
    logic       ext;
    logic       intr1, intr2;
    logic [7:0] status, count;

    int total = 0;
    int bad   = 0;

    io_intr_ctrl #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .port_out_cfg  (cfg),
        .port_out_ctl  (ctl),
        .ext_ev        (ext),
        .intr1         (intr1),
        .intr2         (intr2),
        .port_in_status(status),
        .port_in_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg = 8'h00; ctl = 8'h00; ext = 1'b0;
        tick(); tick();
        total++; if (intr1 !== 1'b0) begin bad++; $display("FAIL rst_intr1 got=%b want=0", intr1); end
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL rst_intr2 got=%b want=0", intr2); end
        total++; if (status !== 8'h00) begin bad++; $display("FAIL rst_status got=%h want=00", status); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL rst_count got=%h want=00", count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_period_ack();
        logic [7:0] ec, es;
        cfg = 8'h03;
        tick();
        ctl = 8'h01;
        for (int i = 0; i < 9; i++) begin
            tick();
            ec = 8'(3 - (i % 4));
            es = (i < 4) ? 8'h10 : ((i < 8) ? 8'h11 : 8'h15);
            total++; if (count !== ec) begin bad++; $display("FAIL period_count[%0d] got=%h want=%h", i, count, ec); end
            total++; if (status !== es) begin bad++; $display("FAIL period_status[%0d] got=%h want=%h", i, status, es); end
            total++; if (intr1 !== (i >= 4)) begin bad++; $display("FAIL period_intr1[%0d] got=%b want=%b", i, intr1, (i >= 4)); end
        end
        ctl = 8'h11;
        tick();
        total++; if (intr1 !== 1'b0) begin bad++; $display("FAIL ack1_intr1 got=%b want=0", intr1); end
        total++; if (status !== 8'h10) begin bad++; $display("FAIL ack1_status got=%h want=10", status); end
        total++; if (count !== 8'h02) begin bad++; $display("FAIL ack1_count got=%h want=02", count); end
        tick(); tick(); tick();
        total++; if (status !== 8'h11) begin bad++; $display("FAIL ackheld_status got=%h want=11", status); end
        total++; if (count !== 8'h03) begin bad++; $display("FAIL ackheld_count got=%h want=03", count); end
        ctl = 8'h01;
        tick();
        total++; if (intr1 !== 1'b1) begin bad++; $display("FAIL ackdrop_intr1 got=%b want=1", intr1); end
        ctl = 8'h11;
        tick();
        total++; if (intr1 !== 1'b0) begin bad++; $display("FAIL reack_intr1 got=%b want=0", intr1); end
        total++; if (count !== 8'h01) begin bad++; $display("FAIL reack_count got=%h want=01", count); end
        ctl = 8'h10;
        tick(); tick(); tick();
        total++; if (count !== 8'h01) begin bad++; $display("FAIL freeze_count got=%h want=01", count); end
        total++; if (status !== 8'h00) begin bad++; $display("FAIL freeze_status got=%h want=00", status); end
    endtask

    task automatic test_cfg_zero();
        cfg = 8'h00;
        ctl = 8'h00;
        tick();
        ctl = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (count !== 8'h00) begin bad++; $display("FAIL cfg0_count[%0d] got=%h want=00", i, count); end
            total++; if (intr1 !== 1'b0) begin bad++; $display("FAIL cfg0_intr1[%0d] got=%b want=0", i, intr1); end
        end
    endtask

    task automatic test_ext_event();
        ctl = 8'h02;
        tick();
        ext = 1'b1;
        tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL ext_k_intr2 got=%b want=0", intr2); end
        tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL ext_k1_intr2 got=%b want=0", intr2); end
        tick();
        total++; if (intr2 !== 1'b1) begin bad++; $display("FAIL ext_k2_intr2 got=%b want=1", intr2); end
        total++; if (status !== 8'h22) begin bad++; $display("FAIL ext_k2_status got=%h want=22", status); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (status !== 8'h22) begin bad++; $display("FAIL ext_held_status got=%h want=22", status); end
        ext = 1'b0;
        tick(); tick(); tick();
        ext = 1'b1;
        tick(); tick(); tick();
        total++; if (status !== 8'h2A) begin bad++; $display("FAIL ext_ovf_status got=%h want=2a", status); end
    endtask

    task automatic test_collision();
        ext = 1'b0;
        tick(); tick(); tick();
        ext = 1'b1;
        tick(); tick();
        ctl = 8'h22;
        tick();
        total++; if (status !== 8'h22) begin bad++; $display("FAIL coll_status got=%h want=22", status); end
        total++; if (intr2 !== 1'b1) begin bad++; $display("FAIL coll_intr2 got=%b want=1", intr2); end
    endtask

    task automatic test_en2_gate();
        ctl = 8'h00;
        tick();
        ctl = 8'h20;
        tick();
        total++; if (status !== 8'h00) begin bad++; $display("FAIL gate_clr_status got=%h want=00", status); end
        ext = 1'b0;
        tick(); tick(); tick();
        ext = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL gate_off_intr2 got=%b want=0", intr2); end
        ctl = 8'h22;
        for (int i = 0; i < 4; i++) tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL gate_on_intr2 got=%b want=0", intr2); end
        total++; if (status !== 8'h20) begin bad++; $display("FAIL gate_on_status got=%h want=20", status); end
    endtask

    task automatic test_reset_mid();
        cfg = 8'h05;
        ctl = 8'h00;
        tick();
        ctl = 8'h03;
        tick();
        total++; if (count !== 8'h05) begin bad++; $display("FAIL mid_load_count got=%h want=05", count); end
        for (int i = 0; i < 9; i++) tick();
        total++; if (count !== 8'h02) begin bad++; $display("FAIL mid_pre_count got=%h want=02", count); end
        total++; if (status !== 8'h31) begin bad++; $display("FAIL mid_pre_status got=%h want=31", status); end
        reset = 1'b0;
        tick();
        total++; if (intr1 !== 1'b0) begin bad++; $display("FAIL mid_rst_intr1 got=%b want=0", intr1); end
        total++; if (status !== 8'h00) begin bad++; $display("FAIL mid_rst_status got=%h want=00", status); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL mid_rst_count got=%h want=00", count); end
        reset = 1'b1;
        tick();
        total++; if (count !== 8'h05) begin bad++; $display("FAIL mid_rel_count got=%h want=05", count); end
        total++; if (status !== 8'h30) begin bad++; $display("FAIL mid_rel_status got=%h want=30", status); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL mid_hi_intr2 got=%b want=0", intr2); end
        ext = 1'b0;
        tick(); tick(); tick();
        ext = 1'b1;
        tick(); tick();
        total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL mid_edge_early got=%b want=0", intr2); end
        tick();
        total++; if (intr2 !== 1'b1) begin bad++; $display("FAIL mid_edge_intr2 got=%b want=1", intr2); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_period_ack();
        test_cfg_zero();
        test_ext_event();
        test_collision();
        test_en2_gate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
